// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch front end.
// Holds the fetch FSM state encoding and the prefetch queue entry layout.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } fetch_state_e;

  localparam int unsigned DEF_PC_STEP  = 4;
  localparam logic [31:0] DEF_RESET_PC = 32'h0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instruction;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO of {pc, instruction} entries with flush, push and pop.
// Head outputs read zero while the queue is empty.
module fetch_queue #(
  parameter int XLEN  = 32,
  parameter int ILEN  = 32,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_flush,
  input  logic            i_push,
  input  logic [XLEN-1:0] i_push_pc,
  input  logic [ILEN-1:0] i_push_ins,
  input  logic            i_pop,
  output logic            o_valid,
  output logic [XLEN-1:0] o_pc,
  output logic [ILEN-1:0] o_ins,
  output logic [CW-1:0]   o_count
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instruction;
  } entry_t;

  entry_t        r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_pop;
  entry_t        w_head;

  assign o_valid = (r_count != '0);
  assign o_count = r_count;
  assign w_pop   = i_pop && o_valid;
  assign w_head  = r_mem[r_rd_ptr];
  assign o_pc    = o_valid ? w_head.pc : '0;
  assign o_ins   = o_valid ? w_head.instruction : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      if (i_push && !w_pop) r_count <= r_count + CW'(1);
      else if (!i_push && w_pop) r_count <= r_count - CW'(1);
    end
  end

  // Storage needs no reset: nothing is visible until count says so.
  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wr_ptr] <= '{pc: i_push_pc, instruction: i_push_ins};
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(i_push && !i_flush && !w_pop && r_count == CW'(DEPTH)));

endmodule

// File: rtl/ins_fetch_unit.sv
// Instruction-fetch front end: PC generation, I-cache busy-wait
// handshake, redirect/drain handling and a prefetch queue to decode.
module ins_fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter int              ILEN        = 32,
  parameter int              QUEUE_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC    = XLEN'(DEF_RESET_PC),
  parameter int unsigned     PC_STEP     = DEF_PC_STEP,
  localparam int             CW          = $clog2(QUEUE_DEPTH) + 1
) (
  input  logic            CLK,
  input  logic            RESET_N,
  output logic [XLEN-1:0] INS_ADDR,
  output logic            INS_READ_EN,
  input  logic [ILEN-1:0] INS_DATA,
  input  logic            INS_CACHE_BUSY_WAIT,
  input  logic            REDIRECT_EN,
  input  logic [XLEN-1:0] REDIRECT_PC,
  output logic            DEC_VALID,
  output logic [ILEN-1:0] DEC_INSTRUCTION,
  output logic [XLEN-1:0] DEC_PC,
  input  logic            DEC_READY,
  output logic [CW-1:0]   QUEUE_COUNT
);

  fetch_state_e    r_state;
  fetch_state_e    w_next_state;
  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] w_next_pc;
  logic [XLEN-1:0] r_pend_pc;
  logic [XLEN-1:0] w_next_pend;
  logic            w_push;
  logic            w_complete;
  logic            w_pop;
  logic [CW:0]     w_cnt_after;

  assign INS_ADDR    = r_fetch_pc;
  assign INS_READ_EN = (r_state == FETCH) || (r_state == DRAIN);
  assign w_complete  = INS_READ_EN && !INS_CACHE_BUSY_WAIT;
  assign w_pop       = DEC_VALID && DEC_READY;
  assign w_cnt_after = {1'b0, QUEUE_COUNT} + (CW+1)'(1) - (CW+1)'(w_pop);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state    <= IDLE;
      r_fetch_pc <= RESET_PC;
      r_pend_pc  <= RESET_PC;
    end else begin
      r_state    <= w_next_state;
      r_fetch_pc <= w_next_pc;
      r_pend_pc  <= w_next_pend;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_pc    = r_fetch_pc;
    w_next_pend  = r_pend_pc;
    w_push       = 1'b0;
    if (REDIRECT_EN) begin
      // A miss still in flight must finish at its own address first.
      if (INS_READ_EN && INS_CACHE_BUSY_WAIT) begin
        w_next_pend  = REDIRECT_PC;
        w_next_state = DRAIN;
      end else begin
        w_next_pc    = REDIRECT_PC;
        w_next_state = FETCH;
      end
    end else begin
      unique case (r_state)
        IDLE: begin
          if (QUEUE_COUNT < CW'(QUEUE_DEPTH)) w_next_state = FETCH;
        end
        FETCH: begin
          if (w_complete) begin
            w_push       = 1'b1;
            w_next_pc    = r_fetch_pc + XLEN'(PC_STEP);
            w_next_state = (w_cnt_after < (CW+1)'(QUEUE_DEPTH)) ? FETCH : IDLE;
          end
        end
        DRAIN: begin
          if (w_complete) begin
            w_next_pc    = r_pend_pc;
            w_next_state = FETCH;
          end
        end
        default: w_next_state = IDLE;
      endcase
    end
  end

  fetch_queue #(
    .XLEN (XLEN),
    .ILEN (ILEN),
    .DEPTH(QUEUE_DEPTH)
  ) u_queue (
    .clk       (CLK),
    .rst_n     (RESET_N),
    .i_flush   (REDIRECT_EN),
    .i_push    (w_push),
    .i_push_pc (r_fetch_pc),
    .i_push_ins(INS_DATA),
    .i_pop     (DEC_READY),
    .o_valid   (DEC_VALID),
    .o_pc      (DEC_PC),
    .o_ins     (DEC_INSTRUCTION),
    .o_count   (QUEUE_COUNT)
  );

endmodule

// File: tb/tb_ins_fetch_unit.sv
// Bench for ins_fetch_unit: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_ins_fetch_unit;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          CLK = 1'b0;
  logic          RESET_N;
  logic [31:0]   INS_ADDR;
  logic          INS_READ_EN;
  logic [31:0]   INS_DATA;
  logic          INS_CACHE_BUSY_WAIT;
  logic          REDIRECT_EN;
  logic [31:0]   REDIRECT_PC;
  logic          DEC_VALID;
  logic [31:0]   DEC_INSTRUCTION;
  logic [31:0]   DEC_PC;
  logic          DEC_READY;
  logic [CW-1:0] QUEUE_COUNT;

  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  ins_fetch_unit #(
    .XLEN(32), .ILEN(32), .QUEUE_DEPTH(DEPTH), .RESET_PC(32'h0), .PC_STEP(4)
  ) dut (
    .CLK                (CLK),
    .RESET_N            (RESET_N),
    .INS_ADDR           (INS_ADDR),
    .INS_READ_EN        (INS_READ_EN),
    .INS_DATA           (INS_DATA),
    .INS_CACHE_BUSY_WAIT(INS_CACHE_BUSY_WAIT),
    .REDIRECT_EN        (REDIRECT_EN),
    .REDIRECT_PC        (REDIRECT_PC),
    .DEC_VALID          (DEC_VALID),
    .DEC_INSTRUCTION    (DEC_INSTRUCTION),
    .DEC_PC             (DEC_PC),
    .DEC_READY          (DEC_READY),
    .QUEUE_COUNT        (QUEUE_COUNT)
  );

  // Reference model: a request flag, a stale flag and a plain queue.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc;
  logic [31:0] m_pend;
  bit          m_req;
  bit          m_stale;

  function automatic void m_reset();
    mq.delete();
    m_pc    = 32'h0;
    m_pend  = 32'h0;
    m_req   = 1'b0;
    m_stale = 1'b0;
  endfunction

  function automatic void m_edge();
    bit done;
    int pre;
    done = m_req && !INS_CACHE_BUSY_WAIT;
    pre  = mq.size();
    if (REDIRECT_EN) begin
      mq.delete();
      if (m_req && INS_CACHE_BUSY_WAIT) begin
        m_pend  = REDIRECT_PC;
        m_stale = 1'b1;
      end else begin
        m_pc    = REDIRECT_PC;
        m_req   = 1'b1;
        m_stale = 1'b0;
      end
    end else begin
      if (pre > 0 && DEC_READY) mq.delete(0);
      if (!m_req) begin
        m_req = (pre < DEPTH);
      end else if (done) begin
        if (m_stale) begin
          m_pc    = m_pend;
          m_stale = 1'b0;
        end else begin
          mq.push_back('{m_pc, INS_DATA});
          m_pc  = m_pc + 32'd4;
          m_req = (mq.size() < DEPTH);
        end
      end
    end
  endfunction

  task automatic step(input bit busy, input bit rdy, input bit redir,
                      input logic [31:0] rpc);
    INS_CACHE_BUSY_WAIT = busy;
    DEC_READY           = rdy;
    REDIRECT_EN         = redir;
    REDIRECT_PC         = rpc;
    INS_DATA            = $urandom;
    @(posedge CLK);
    m_edge();
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RESET_N             = 1'b0;
    INS_CACHE_BUSY_WAIT = 1'b0;
    DEC_READY           = 1'b0;
    REDIRECT_EN         = 1'b0;
    REDIRECT_PC         = 32'h0;
    INS_DATA            = 32'h0;
    @(negedge CLK);
    m_reset();
    @(negedge CLK);
    RESET_N = 1'b1;
  endtask

  task automatic test_reset();
    RESET_N             = 1'b0;
    INS_CACHE_BUSY_WAIT = 1'b0;
    DEC_READY           = 1'b1;
    REDIRECT_EN         = 1'b0;
    REDIRECT_PC         = 32'h0;
    INS_DATA            = 32'hdead_beef;
    m_reset();
    repeat (2) @(negedge CLK);
    n_cmp++;
    if (INS_READ_EN !== 1'b0) begin
      n_err++; $display("FAIL reset_rden got %0h want 0", INS_READ_EN);
    end
    n_cmp++;
    if (DEC_VALID !== 1'b0) begin
      n_err++; $display("FAIL reset_valid got %0h want 0", DEC_VALID);
    end
    n_cmp++;
    if (QUEUE_COUNT !== '0) begin
      n_err++; $display("FAIL reset_count got %0d want 0", QUEUE_COUNT);
    end
    n_cmp++;
    if (INS_ADDR !== 32'h0) begin
      n_err++; $display("FAIL reset_addr got %0h want 0", INS_ADDR);
    end
    n_cmp++;
    if (DEC_PC !== 32'h0 || DEC_INSTRUCTION !== 32'h0) begin
      n_err++;
      $display("FAIL reset_head got pc=%0h ins=%0h want 0/0", DEC_PC, DEC_INSTRUCTION);
    end
  endtask

  task automatic test_start();
    do_reset();
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 1'b1, 1'b0, 32'h0);
      n_cmp++;
      if (INS_READ_EN !== 1'b1 || INS_ADDR !== 32'(4 * k)) begin
        n_err++;
        $display("FAIL start_addr k=%0d got en=%0h addr=%0h want 1/%0h",
                 k, INS_READ_EN, INS_ADDR, 4 * k);
      end
      if (k > 0) begin
        n_cmp++;
        if (DEC_VALID !== 1'b1 || DEC_PC !== 32'(4 * (k - 1)) || DEC_INSTRUCTION !== INS_DATA) begin
          n_err++;
          $display("FAIL start_head k=%0d got v=%0h pc=%0h ins=%0h want 1/%0h/%0h",
                   k, DEC_VALID, DEC_PC, DEC_INSTRUCTION, 4 * (k - 1), INS_DATA);
        end
      end
    end
  endtask

  task automatic test_miss();
    do_reset();
    repeat (3) step(1'b0, 1'b1, 1'b0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (INS_ADDR !== 32'h8 || INS_READ_EN !== 1'b1) begin
        n_err++; $display("FAIL miss_hold k=%0d got addr=%0h want 8", k, INS_ADDR);
      end
      step(1'b1, 1'b1, 1'b0, 32'h0);
    end
    n_cmp++;
    if (INS_ADDR !== 32'h8) begin
      n_err++; $display("FAIL miss_hold4 got addr=%0h want 8", INS_ADDR);
    end
    step(1'b0, 1'b1, 1'b0, 32'h0);
    n_cmp++;
    if (INS_ADDR !== 32'hC || QUEUE_COUNT !== CW'(1) || DEC_PC !== 32'h8) begin
      n_err++;
      $display("FAIL miss_done got addr=%0h cnt=%0d pc=%0h want c/1/8",
               INS_ADDR, QUEUE_COUNT, DEC_PC);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    repeat (8) step(1'b0, 1'b0, 1'b0, 32'h0);
    n_cmp++;
    if (QUEUE_COUNT !== CW'(DEPTH) || INS_READ_EN !== 1'b0 || DEC_PC !== 32'h0) begin
      n_err++;
      $display("FAIL bp_full got cnt=%0d en=%0h pc=%0h want 4/0/0",
               QUEUE_COUNT, INS_READ_EN, DEC_PC);
    end
    step(1'b0, 1'b1, 1'b0, 32'h0);
    n_cmp++;
    if (QUEUE_COUNT !== CW'(3) || DEC_PC !== 32'h4 || INS_READ_EN !== 1'b0) begin
      n_err++;
      $display("FAIL bp_pop got cnt=%0d pc=%0h en=%0h want 3/4/0",
               QUEUE_COUNT, DEC_PC, INS_READ_EN);
    end
    step(1'b0, 1'b0, 1'b0, 32'h0);
    n_cmp++;
    if (INS_READ_EN !== 1'b1 || INS_ADDR !== 32'h10) begin
      n_err++;
      $display("FAIL bp_refetch got en=%0h addr=%0h want 1/10", INS_READ_EN, INS_ADDR);
    end
  endtask

  task automatic test_redirect_miss();
    do_reset();
    repeat (6) step(1'b0, 1'b1, 1'b0, 32'h0);
    n_cmp++;
    if (INS_ADDR !== 32'h14) begin
      n_err++; $display("FAIL rdm_pre got addr=%0h want 14", INS_ADDR);
    end
    step(1'b1, 1'b1, 1'b1, 32'h100);
    n_cmp++;
    if (INS_ADDR !== 32'h14 || INS_READ_EN !== 1'b1 || DEC_VALID !== 1'b0) begin
      n_err++;
      $display("FAIL rdm_drain got addr=%0h en=%0h v=%0h want 14/1/0",
               INS_ADDR, INS_READ_EN, DEC_VALID);
    end
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    n_cmp++;
    if (INS_ADDR !== 32'h100 || DEC_VALID !== 1'b0) begin
      n_err++;
      $display("FAIL rdm_discard got addr=%0h v=%0h want 100/0", INS_ADDR, DEC_VALID);
    end
    step(1'b0, 1'b1, 1'b0, 32'h0);
    n_cmp++;
    if (DEC_VALID !== 1'b1 || DEC_PC !== 32'h100 || INS_ADDR !== 32'h104) begin
      n_err++;
      $display("FAIL rdm_target got v=%0h pc=%0h addr=%0h want 1/100/104",
               DEC_VALID, DEC_PC, INS_ADDR);
    end
  endtask

  task automatic test_redirect_flush();
    do_reset();
    repeat (3) step(1'b0, 1'b0, 1'b0, 32'h0);
    n_cmp++;
    if (QUEUE_COUNT !== CW'(2)) begin
      n_err++; $display("FAIL rdf_pre got cnt=%0d want 2", QUEUE_COUNT);
    end
    step(1'b0, 1'b1, 1'b1, 32'h40);
    n_cmp++;
    if (QUEUE_COUNT !== '0 || INS_ADDR !== 32'h40 || INS_READ_EN !== 1'b1) begin
      n_err++;
      $display("FAIL rdf_flush got cnt=%0d addr=%0h en=%0h want 0/40/1",
               QUEUE_COUNT, INS_ADDR, INS_READ_EN);
    end
    step(1'b1, 1'b0, 1'b1, 32'h200);
    step(1'b1, 1'b0, 1'b1, 32'h300);
    n_cmp++;
    if (INS_ADDR !== 32'h40) begin
      n_err++; $display("FAIL rdf_hold got addr=%0h want 40", INS_ADDR);
    end
    step(1'b0, 1'b0, 1'b0, 32'h0);
    n_cmp++;
    if (INS_ADDR !== 32'h300 || QUEUE_COUNT !== '0) begin
      n_err++;
      $display("FAIL rdf_latest got addr=%0h cnt=%0d want 300/0", INS_ADDR, QUEUE_COUNT);
    end
    step(1'b0, 1'b0, 1'b0, 32'h0);
    n_cmp++;
    if (DEC_PC !== 32'h300 || QUEUE_COUNT !== CW'(1)) begin
      n_err++;
      $display("FAIL rdf_head got pc=%0h cnt=%0d want 300/1", DEC_PC, QUEUE_COUNT);
    end
  endtask

  task automatic test_reset_mid_miss();
    do_reset();
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    #2 RESET_N = 1'b0;
    #1;
    n_cmp++;
    if (INS_READ_EN !== 1'b0 || DEC_VALID !== 1'b0 || QUEUE_COUNT !== '0) begin
      n_err++;
      $display("FAIL rmm_async got en=%0h v=%0h cnt=%0d want 0/0/0",
               INS_READ_EN, DEC_VALID, QUEUE_COUNT);
    end
    m_reset();
    @(negedge CLK);
    RESET_N = 1'b1;
    step(1'b0, 1'b1, 1'b0, 32'h0);
    n_cmp++;
    if (INS_READ_EN !== 1'b1 || INS_ADDR !== 32'h0) begin
      n_err++;
      $display("FAIL rmm_restart got en=%0h addr=%0h want 1/0", INS_READ_EN, INS_ADDR);
    end
  endtask

  task automatic test_random();
    logic [31:0] e_pc;
    logic [31:0] e_ins;
    do_reset();
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 15) == 0, $urandom & 32'hFFFF_FFFC);
      e_pc  = (mq.size() > 0) ? mq[0].pc : 32'h0;
      e_ins = (mq.size() > 0) ? mq[0].ins : 32'h0;
      n_cmp++;
      if (INS_READ_EN !== m_req) begin
        n_err++; $display("FAIL rnd_rden i=%0d got %0h want %0h", i, INS_READ_EN, m_req);
      end
      n_cmp++;
      if (INS_ADDR !== m_pc) begin
        n_err++; $display("FAIL rnd_addr i=%0d got %0h want %0h", i, INS_ADDR, m_pc);
      end
      n_cmp++;
      if (QUEUE_COUNT !== CW'(mq.size())) begin
        n_err++; $display("FAIL rnd_count i=%0d got %0d want %0d", i, QUEUE_COUNT, mq.size());
      end
      n_cmp++;
      if (DEC_VALID !== (mq.size() > 0)) begin
        n_err++; $display("FAIL rnd_valid i=%0d got %0h want %0h", i, DEC_VALID, mq.size() > 0);
      end
      n_cmp++;
      if (DEC_PC !== e_pc || DEC_INSTRUCTION !== e_ins) begin
        n_err++;
        $display("FAIL rnd_head i=%0d got %0h/%0h want %0h/%0h",
                 i, DEC_PC, DEC_INSTRUCTION, e_pc, e_ins);
      end
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_miss();
    test_backpressure();
    test_redirect_miss();
    test_redirect_flush();
    test_reset_mid_miss();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ins_fetch_unit.md
Name: ins_fetch_unit

Overview:
- Parametrised instruction-fetch front end for the RV32IM pipeline, replacing the single-register fetch stage.
- Generates the PC and drives the instruction-cache busy-wait handshake.
- Buffers fetched instructions in a QUEUE_DEPTH-entry prefetch queue that feeds decode with a valid/ready handshake.
- Handles branch/jump redirects, including a redirect that arrives while a cache miss is still in flight.

Parameters:
- XLEN, 32, PC/address width.
- ILEN, 32, instruction width.
- QUEUE_DEPTH, 4, prefetch queue entries; power of two, at least 2.
- RESET_PC, 0, first fetch address after reset.
- PC_STEP, 4, sequential PC increment.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- INS_ADDR  out  XLEN  fetch address to the instruction cache (= fetch_pc register).
- INS_READ_EN  out  1  read request to the instruction cache.
- INS_DATA  in  ILEN  instruction returned by the cache.
- INS_CACHE_BUSY_WAIT  in  1  cache not yet done; the request must be held.
- REDIRECT_EN  in  1  branch/jump taken from the execute stage; flush and refetch.
- REDIRECT_PC  in  XLEN  redirect target.
- DEC_VALID  out  1  queue head valid.
- DEC_INSTRUCTION  out  ILEN  queue head instruction.
- DEC_PC  out  XLEN  PC of the queue head.
- DEC_READY  in  1  decode accepts the head this cycle.
- QUEUE_COUNT  out  $clog2(QUEUE_DEPTH)+1  occupied entries (debug).

Behaviour:
Reset (RESET_N low, asynchronous):
- fetch_pc=RESET_PC, state=IDLE, count=0, both pointers=0.
- INS_READ_EN=0, DEC_VALID=0, QUEUE_COUNT=0.
- DEC_INSTRUCTION/DEC_PC read 0 while empty.
- Reset asserted mid-miss abandons the request immediately; the cache is expected to tolerate the dropped read.

States:
- IDLE: no request.
- FETCH: request at fetch_pc.
- DRAIN: stale miss in flight, result discarded.
- INS_READ_EN = (state==FETCH || state==DRAIN). INS_ADDR = fetch_pc and is held stable while BUSY_WAIT is high.

Completion:
- A rising edge with INS_READ_EN=1 and INS_CACHE_BUSY_WAIT=0 completes the request.
- A hit with BUSY_WAIT low in the same cycle gives one instruction per cycle.
- Exactly one request is outstanding at a time.

Transitions when REDIRECT_EN=0:
- IDLE -> FETCH when count<QUEUE_DEPTH.
- FETCH, completing:
  - enqueue {fetch_pc, INS_DATA}; fetch_pc += PC_STEP (mod 2^XLEN).
  - stay in FETCH if post-update count<QUEUE_DEPTH, else go to IDLE.
- FETCH, not completing: hold.
- DRAIN, completing: discard data; fetch_pc=pending_pc; go to FETCH.

REDIRECT_EN=1 (has priority over everything in the same cycle):
- Queue flushed to count=0; any simultaneous DEC_READY dequeue and any simultaneous completion are dropped.
- If state==FETCH and BUSY_WAIT=1: pending_pc=REDIRECT_PC, go to DRAIN (fetch_pc unchanged until the drain completes).
- Otherwise: fetch_pc=REDIRECT_PC, go to FETCH.
- Redirect while already in DRAIN: pending_pc updates; the latest redirect wins.
- The head presented in the redirect cycle is stale; discarding it is decode's flush responsibility.

Queue:
- DEC_VALID = (count!=0). Head outputs are taken combinationally from the storage at rd_ptr.
- Dequeue when DEC_VALID && DEC_READY. DEC_READY while empty is ignored (no underflow).
- Simultaneous enqueue and dequeue: count unchanged, both pointers advance.
- Pointers wrap modulo QUEUE_DEPTH.
- Overflow cannot occur: FETCH is only entered or kept with count<QUEUE_DEPTH, and count only grows via the single outstanding request. An assertion flags enqueue while full.

Decomposition:
- Package fetch_pkg: state enum {IDLE, FETCH, DRAIN}, default PC_STEP, RESET_PC localparams, queue-entry struct {pc, instruction}.
- Sub-module fetch_queue: synchronous FIFO of entries with flush, push, pop, count, and head outputs.
- ins_fetch_unit holds the FSM, fetch_pc, and pending_pc.

Test Plan:
- Reset/start: RESET_N low then high, cache always ready, DEC_READY=1.
  -> INS_READ_EN rises one cycle after release; INS_ADDR 0,4,8,… on consecutive cycles; DEC_PC follows one cycle later with the matching INS_DATA.
- Miss: BUSY_WAIT high for 3 cycles at address 0x8.
  -> INS_ADDR held at 0x8 for 4 cycles; a single entry PC 0x8 is enqueued; next address is 0xC.
- Backpressure: DEC_READY=0, QUEUE_DEPTH=4.
  -> exactly 4 entries (PCs 0x0–0xC); INS_READ_EN drops; QUEUE_COUNT=4.
  -> raising DEC_READY for one cycle gives one dequeue, then a fetch at 0x10.
- Redirect during miss: BUSY_WAIT high at 0x14, REDIRECT_EN with REDIRECT_PC=0x100.
  -> state DRAIN, INS_ADDR stays 0x14 until BUSY_WAIT falls, that data is not enqueued, then INS_ADDR=0x100 and the next DEC_PC=0x100.
- Redirect with simultaneous dequeue and completion, queue holding 2 entries.
  -> QUEUE_COUNT=0 next cycle, INS_ADDR=REDIRECT_PC; the double redirect 0x200 then 0x300 during DRAIN fetches 0x300.
- Reset mid-miss: RESET_N low while BUSY_WAIT high.
  -> INS_READ_EN=0 and DEC_VALID=0 immediately (asynchronous); restart fetches at RESET_PC.
